// File: rtl/xadac_pkg.sv
// rtl/xadac_pkg.sv - shared widths, types and helpers for the xadac vector writeback stage
//
// Contents: element/beat geometry, vreg address and vlen types, the buffered
// response record (vwb_entry_t), writeback FSM states and small helpers.
package xadac_pkg;

    localparam int SumWidth      = 32;
    localparam int VecLen        = 8;
    localparam int BeatWidth     = 64;
    localparam int NumVregs      = 32;
    localparam int IdWidth       = 4;

    localparam int VecLenWidth   = $clog2(VecLen + 1);
    localparam int ElemsPerBeat  = BeatWidth / SumWidth;
    localparam int NumBeats      = VecLen / ElemsPerBeat;
    localparam int VregAddrWidth = $clog2(NumVregs);
    localparam int BeatIdxWidth  = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam int VdWidth       = VecLen * SumWidth;

    typedef logic [VecLenWidth-1:0]   VecLenT;
    typedef logic [VregAddrWidth-1:0] VregAddrT;
    typedef logic [BeatIdxWidth-1:0]  beat_idx_t;
    typedef logic [IdWidth-1:0]       id_t;

    typedef struct packed {
        id_t                id;
        VregAddrT           vaddr;
        VecLenT             vlen;
        logic [VdWidth-1:0] vd;
    } vwb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_COMMIT = 2'd2
    } vwb_state_e;

    // Number of VRF beats needed to cover vlen active elements.
    function automatic VecLenT beats_for(input VecLenT vlen);
        return VecLenT'((int'(vlen) + ElemsPerBeat - 1) / ElemsPerBeat);
    endfunction

    // Out-of-range lengths are treated as a full vector.
    function automatic VecLenT clamp_vlen(input VecLenT vlen);
        return (int'(vlen) > VecLen) ? VecLenT'(VecLen) : vlen;
    endfunction

endpackage

// File: rtl/xadac_vwb_fifo.sv
// rtl/xadac_vwb_fifo.sv - in-order response buffer holding vwb_entry_t records
//
// Ports: clk, rstn (async active-low), push/wdata (write side),
//        pop/rdata (read side, rdata is the current head), full, empty.
module xadac_vwb_fifo
    import xadac_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  vwb_entry_t wdata,
    input  logic       pop,
    output vwb_entry_t rdata,
    output logic       full,
    output logic       empty
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    vwb_entry_t        mem [Depth];
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [CntW-1:0]   count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/xadac_vwb.sv
// rtl/xadac_vwb.sv - vector writeback: buffers exe responses, writes vd to the VRF in beats, commits in order
//
// Ports: clk, rstn (async active-low)
//        rsp_*  : exe response input (valid/ready, id, vaddr, vlen, vd)
//        vrf_*  : VRF write port (we/wready, waddr, wbeat, wdata, wmask)
//        cmt_*  : scoreboard commit (valid/ready, id, vaddr)
//        busy   : buffer non-empty or writeback in progress
module xadac_vwb
    import xadac_pkg::*;
#(
    parameter int FifoDepth = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     rsp_valid,
    output logic                     rsp_ready,
    input  logic [IdWidth-1:0]       rsp_id,
    input  logic [VregAddrWidth-1:0] rsp_vaddr,
    input  logic [VecLenWidth-1:0]   rsp_vlen,
    input  logic [VdWidth-1:0]       rsp_vd,
    output logic                     vrf_we,
    input  logic                     vrf_wready,
    output logic [VregAddrWidth-1:0] vrf_waddr,
    output logic [BeatIdxWidth-1:0]  vrf_wbeat,
    output logic [BeatWidth-1:0]     vrf_wdata,
    output logic [ElemsPerBeat-1:0]  vrf_wmask,
    output logic                     cmt_valid,
    input  logic                     cmt_ready,
    output logic [IdWidth-1:0]       cmt_id,
    output logic [VregAddrWidth-1:0] cmt_vaddr,
    output logic                     busy
);

    vwb_entry_t in_entry;
    vwb_entry_t head;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       last_beat;

    vwb_state_e state, state_next;
    beat_idx_t  beat_q, beat_d;

    // Ready depends only on the registered fill level, so a same-cycle pop
    // never opens a slot early.
    assign rsp_ready = !full;
    assign push      = rsp_valid && !full;
    assign in_entry  = '{id: rsp_id, vaddr: rsp_vaddr, vlen: clamp_vlen(rsp_vlen), vd: rsp_vd};

    xadac_vwb_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (in_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign last_beat = ((VecLenT'(beat_q) + VecLenT'(1)) == beats_for(head.vlen));
    assign busy      = !empty || (state != ST_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            beat_q <= '0;
        end else begin
            state  <= state_next;
            beat_q <= beat_d;
        end
    end

    always_comb begin
        state_next = state;
        beat_d     = beat_q;
        vrf_we     = 1'b0;
        cmt_valid  = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    beat_d     = '0;
                    state_next = (head.vlen == '0) ? ST_COMMIT : ST_WRITE;
                end
            end
            ST_WRITE: begin
                vrf_we = 1'b1;
                if (vrf_wready) begin
                    if (last_beat) begin
                        state_next = ST_COMMIT;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                cmt_valid = 1'b1;
                if (cmt_ready) begin
                    pop        = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Payload outputs are forced to zero whenever their strobe is low, so the
    // buffer's stale head never leaks onto the ports. Inactive lanes still
    // carry vd data; only the mask marks them.
    always_comb begin
        vrf_waddr = '0;
        vrf_wbeat = '0;
        vrf_wdata = '0;
        vrf_wmask = '0;
        cmt_id    = '0;
        cmt_vaddr = '0;
        if (state == ST_WRITE) begin
            vrf_waddr = head.vaddr;
            vrf_wbeat = beat_q;
            vrf_wdata = head.vd[beat_q*BeatWidth +: BeatWidth];
            for (int l = 0; l < ElemsPerBeat; l++) begin
                vrf_wmask[l] = ((int'(beat_q) * ElemsPerBeat + l) < int'(head.vlen));
            end
        end
        if (state == ST_COMMIT) begin
            cmt_id    = head.id;
            cmt_vaddr = head.vaddr;
        end
    end

endmodule

// File: tb/tb_xadac_vwb.sv
// tb/tb_xadac_vwb.sv - self-checking bench for xadac_vwb
module tb_xadac_vwb;
    import xadac_pkg::*;

    logic         clk = 1'b0;
    logic         rstn;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [3:0]   rsp_id;
    logic [4:0]   rsp_vaddr;
    logic [3:0]   rsp_vlen;
    logic [255:0] rsp_vd;
    logic         vrf_we;
    logic         vrf_wready;
    logic [4:0]   vrf_waddr;
    logic [1:0]   vrf_wbeat;
    logic [63:0]  vrf_wdata;
    logic [1:0]   vrf_wmask;
    logic         cmt_valid;
    logic         cmt_ready;
    logic [3:0]   cmt_id;
    logic [4:0]   cmt_vaddr;
    logic         busy;

    always #5 clk = ~clk;

    xadac_vwb #(.FifoDepth(2)) dut (
        .clk(clk), .rstn(rstn),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_vaddr(rsp_vaddr), .rsp_vlen(rsp_vlen), .rsp_vd(rsp_vd),
        .vrf_we(vrf_we), .vrf_wready(vrf_wready), .vrf_waddr(vrf_waddr),
        .vrf_wbeat(vrf_wbeat), .vrf_wdata(vrf_wdata), .vrf_wmask(vrf_wmask),
        .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_id(cmt_id),
        .cmt_vaddr(cmt_vaddr), .busy(busy)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic [1:0]  beat;
        logic [63:0] data;
        logic [1:0]  mask;
    } exp_beat_t;

    typedef struct {
        logic [3:0] id;
        logic [4:0] vaddr;
    } exp_cmt_t;

    exp_beat_t exp_beats[$];
    exp_cmt_t  exp_cmts[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          wr_count  = 0;
    int          cmt_pops  = 0;
    int          cmt_seen  = 0;
    int          first_we  = -1;
    int          first_cmt = -1;
    int          first_pop = -1;
    logic [1:0]  last_mask = '0;
    logic [63:0] b0_data   = '0;
    bit          mon_en    = 0;

    // Scoreboard model: one expected beat per ceil(vlen/2), one commit per response.
    task automatic expect_rsp(input logic [3:0] id, input logic [4:0] vaddr, input int vlen,
                              input logic [255:0] vd);
        int vl;
        exp_beat_t e;
        exp_cmt_t  c;
        vl = (vlen > 8) ? 8 : vlen;
        for (int b = 0; b < (vl + 1) / 2; b++) begin
            e.addr = vaddr;
            e.beat = 2'(b);
            e.data = vd[64*b +: 64];
            for (int l = 0; l < 2; l++) e.mask[l] = (b * 2 + l < vl);
            exp_beats.push_back(e);
        end
        c.id    = id;
        c.vaddr = vaddr;
        exp_cmts.push_back(c);
    endtask

    always @(negedge clk) begin
        if (mon_en && rstn) begin
            if (vrf_we) begin
                if (first_we < 0) first_we = cyc;
                if (vrf_wready) begin
                    exp_beat_t e;
                    check("write_expected", 64'(exp_beats.size() > 0), 64'd1);
                    if (exp_beats.size() > 0) begin
                        e = exp_beats.pop_front();
                        check("wr_addr", vrf_waddr, e.addr);
                        check("wr_beat", vrf_wbeat, e.beat);
                        check("wr_data", vrf_wdata, e.data);
                        check("wr_mask", vrf_wmask, e.mask);
                    end
                    wr_count++;
                    last_mask = vrf_wmask;
                    if (vrf_wbeat == 2'd0) b0_data = vrf_wdata;
                end
            end
            if (cmt_valid) begin
                cmt_seen++;
                if (first_cmt < 0) first_cmt = cyc;
                if (cmt_ready) begin
                    exp_cmt_t c;
                    check("commit_expected", 64'(exp_cmts.size() > 0), 64'd1);
                    if (exp_cmts.size() > 0) begin
                        c = exp_cmts.pop_front();
                        check("cmt_id", cmt_id, c.id);
                        check("cmt_vaddr", cmt_vaddr, c.vaddr);
                    end
                    cmt_pops++;
                    if (first_pop < 0) first_pop = cyc;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] id, input logic [4:0] vaddr, input int vlen,
                        input logic [255:0] vd, output int acc);
        rsp_id    = id;
        rsp_vaddr = vaddr;
        rsp_vlen  = 4'(vlen);
        rsp_vd    = vd;
        rsp_valid = 1'b1;
        acc       = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rsp_ready) begin
                acc = cyc;
                expect_rsp(id, vaddr, vlen, vd);
                break;
            end
        end
        if (acc < 0) begin
            check("send_accepted", 64'd0, 64'd1);
            rsp_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 rsp_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!busy && exp_beats.size() == 0 && exp_cmts.size() == 0) begin
                done = 1;
                break;
            end
        end
        check("idle_reached", 64'(done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] inc_vd();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = 32'h10 + 32'(i);
        return v;
    endfunction

    function automatic logic [255:0] rnd_vd();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    typedef struct {
        logic [3:0]   id;
        logic [4:0]   vaddr;
        int           vlen;
        logic [255:0] vd;
        int           nbeats;
        logic [1:0]   last_mask;
        logic [63:0]  b0data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, acc_b, acc_c, wr0, pops0, seen0;
        bit found;
        logic [255:0] vd;
        logic [63:0]  cap_data;
        logic [1:0]   cap_mask;

        rstn = 1'b0; rsp_valid = 1'b0; rsp_id = '0; rsp_vaddr = '0; rsp_vlen = '0;
        rsp_vd = '0; vrf_wready = 1'b1; cmt_ready = 1'b1;

        vecs[0] = '{4'd3,  5'd5,  8,  inc_vd(), 4, 2'b11, 64'h00000011_00000010};
        vecs[1] = '{4'd7,  5'd12, 3,  inc_vd(), 2, 2'b01, 64'h00000011_00000010};
        vecs[2] = '{4'd9,  5'd31, 0,  rnd_vd(), 0, 2'b00, 64'd0};
        vecs[3] = '{4'd15, 5'd0,  15, rnd_vd(), 4, 2'b11, 64'd0};
        vecs[4] = '{4'd1,  5'd7,  1,  rnd_vd(), 1, 2'b01, 64'd0};
        vecs[5] = '{4'd4,  5'd20, 6,  rnd_vd(), 3, 2'b11, 64'd0};
        for (int i = 2; i < 6; i++) vecs[i].b0data = vecs[i].vd[63:0];

        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_ready", rsp_ready, 1);
        check("rst_vrf_we", vrf_we, 0);
        check("rst_cmt_valid", cmt_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_wdata", vrf_wdata, 0);
        check("rst_wmask", vrf_wmask, 0);
        check("rst_cmt_id", cmt_id, 0);
        rstn = 1'b1;
        mon_en = 1;
        @(posedge clk);
        #1;

        // Table-driven single responses.
        for (int i = 0; i < 6; i++) begin
            wr0 = wr_count; first_we = -1; first_cmt = -1; last_mask = '0; b0_data = '0;
            send(vecs[i].id, vecs[i].vaddr, vecs[i].vlen, vecs[i].vd, acc);
            wait_idle();
            check($sformatf("v%0d_nbeats", i), 64'(wr_count - wr0), 64'(vecs[i].nbeats));
            if (vecs[i].nbeats > 0) begin
                check($sformatf("v%0d_we_latency", i), 64'(first_we - acc), 64'd2);
                check($sformatf("v%0d_last_mask", i), last_mask, vecs[i].last_mask);
                check($sformatf("v%0d_beat0_data", i), b0_data, vecs[i].b0data);
            end else begin
                check($sformatf("v%0d_no_write", i), 64'(first_we), 64'hFFFF_FFFF_FFFF_FFFF);
                check($sformatf("v%0d_cmt_latency", i), 64'(first_cmt - acc), 64'd2);
            end
        end

        // wready stall on beat 1.
        vd = rnd_vd();
        wr0 = wr_count;
        send(4'd2, 5'd9, 8, vd, acc);
        found = 0;
        for (int n = 0; n < 50; n++) begin
            if (vrf_we && vrf_wbeat == 2'd1) begin found = 1; break; end
            @(posedge clk);
            #1;
        end
        check("stall_beat1_seen", 64'(found), 64'd1);
        vrf_wready = 1'b0;
        cap_data = vrf_wdata;
        cap_mask = vrf_wmask;
        check("stall_data", cap_data, vd[127:64]);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin @(posedge clk); #1 vrf_wready = 1'b1; end
            @(negedge clk);
            check($sformatf("stall_we_%0d", k), vrf_we, 1);
            check($sformatf("stall_beat_%0d", k), vrf_wbeat, 1);
            check($sformatf("stall_hold_data_%0d", k), vrf_wdata, cap_data);
            check($sformatf("stall_hold_mask_%0d", k), vrf_wmask, cap_mask);
            check($sformatf("stall_hold_addr_%0d", k), vrf_waddr, 9);
        end
        @(posedge clk);
        #1;
        wait_idle();
        check("stall_total_writes", 64'(wr_count - wr0), 64'd4);

        // Back-pressure from the commit side with three responses.
        cmt_ready = 1'b0;
        pops0 = cmt_pops;
        first_pop = -1;
        send(4'd10, 5'd1, 2, rnd_vd(), acc);
        send(4'd11, 5'd2, 2, rnd_vd(), acc_b);
        check("b2b_accept", 64'(acc_b - acc), 64'd1);
        @(negedge clk);
        check("full_rsp_ready", rsp_ready, 0);
        fork
            send(4'd12, 5'd3, 2, rnd_vd(), acc_c);
            begin
                repeat (6) @(posedge clk);
                #1 cmt_ready = 1'b1;
            end
        join
        check("third_after_pop", 64'(acc_c - first_pop), 64'd1);
        wait_idle();
        check("three_commits", 64'(cmt_pops - pops0), 64'd3);

        // Reset during beat 2.
        send(4'd6, 5'd14, 8, rnd_vd(), acc);
        found = 0;
        for (int n = 0; n < 50; n++) begin
            if (vrf_we && vrf_wbeat == 2'd2) begin found = 1; break; end
            @(posedge clk);
            #1;
        end
        check("rst_beat2_seen", 64'(found), 64'd1);
        mon_en = 0;
        #2 rstn = 1'b0;
        #1;
        check("midrst_we", vrf_we, 0);
        check("midrst_cmt_valid", cmt_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wdata", vrf_wdata, 0);
        exp_beats.delete();
        exp_cmts.delete();
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        mon_en = 1;
        seen0 = cmt_seen;
        wr0 = wr_count;
        repeat (10) @(negedge clk);
        check("postrst_busy", busy, 0);
        check("postrst_rsp_ready", rsp_ready, 1);
        check("postrst_no_commit", 64'(cmt_seen - seen0), 64'd0);
        check("postrst_no_write", 64'(wr_count - wr0), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
